// File: rtl/k6502_pkg.sv
// Shared types for the k6502 control path: datapath control word, opcodes, T-state encoding.
package k6502_pkg;

    typedef struct packed {
        logic z_adl0;
        logic z_adl1;
        logic adl_abl;
        logic adh_abh;
        logic dl_db;
        logic db_add;
        logic z_add;
        logic sums;
        logic dl_adh;
        logic adh_pch;
        logic add_adl;
        logic adl_pcl;
        logic pcl_adl;
        logic pch_adh;
        logic pcl_pcl;
        logic pch_pch;
        logic i_pc;
        logic ac_sb;
        logic sb_x;
        logic sb_y;
        logic x_sb;
        logic y_sb;
        logic s_sb;
        logic sb_ac;
        logic sb_s;
        logic sb_db;
    } control_signals_t;

    localparam logic [7:0] OP_TAX     = 8'hAA;
    localparam logic [7:0] OP_TAY     = 8'hA8;
    localparam logic [7:0] OP_TXA     = 8'h8A;
    localparam logic [7:0] OP_TYA     = 8'h98;
    localparam logic [7:0] OP_TXS     = 8'h9A;
    localparam logic [7:0] OP_TSX     = 8'hBA;
    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;

    typedef enum logic [2:0] {
        StT0  = 3'd0,
        StT1  = 3'd1,
        StT2  = 3'd2,
        StT3  = 3'd3,
        StJam = 3'd4,
        StR1  = 3'd5,
        StR2  = 3'd6,
        StR3  = 3'd7
    } t_state_e;

    // Drive PC onto the address bus and write it back; inc selects the increment.
    function automatic control_signals_t pc_fetch_ctl(input logic inc);
        control_signals_t c;
        c         = '0;
        c.pcl_adl = 1'b1;
        c.pch_adh = 1'b1;
        c.adl_abl = 1'b1;
        c.adh_abh = 1'b1;
        c.pcl_pcl = 1'b1;
        c.pch_pch = 1'b1;
        c.i_pc    = inc;
        return c;
    endfunction

    // Load PC from {data latch, adder hold}: shared by the reset vector and JMP abs.
    function automatic control_signals_t jump_ctl();
        control_signals_t c;
        c         = '0;
        c.dl_adh  = 1'b1;
        c.adh_pch = 1'b1;
        c.add_adl = 1'b1;
        c.adl_pcl = 1'b1;
        c.adl_abl = 1'b1;
        c.adh_abh = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/k6502_phase_gen.sv
// Two-phase clock generator: one CPU cycle is a ph1 clk followed by a ph2 clk.
module k6502_phase_gen (
    input  logic clk,
    input  logic rst,
    output logic ph1,
    output logic ph2,
    output logic cycle_end
);

    logic ph1_q;
    logic ph2_q;

    // Both phases idle low in reset so the first clk afterwards starts a fresh ph1.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph1_q <= 1'b0;
            ph2_q <= 1'b0;
        end else begin
            ph1_q <= ~ph1_q;
            ph2_q <= ph1_q;
        end
    end

    assign ph1       = ph1_q;
    assign ph2       = ph2_q;
    assign cycle_end = ph2_q;

endmodule

// File: rtl/k6502_control.sv
// k6502 control/timing generator: reset vector, opcode fetch, per-T-state control words.
// Define K6502_CTL_ILLEGAL_TRAP_EN to halt in JAM on illegal opcodes (else they act as NOP).
module k6502_control
    import k6502_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       d_in,
    output logic             ph1,
    output logic             ph2,
    output control_signals_t ctl,
    output logic             rw,
    output logic             sync,
    output logic [2:0]       t_state,
    output logic             jam
);

    logic             cycle_end;
    logic             running;
    t_state_e         state_q, state_d;
    logic [7:0]       ir_q;
    logic [7:0]       pd_q;
    logic [7:0]       pd_d;
    logic [7:0]       op;
    control_signals_t ctl_raw;

    k6502_phase_gen u_phase_gen (
        .clk       (clk),
        .rst       (rst),
        .ph1       (ph1),
        .ph2       (ph2),
        .cycle_end (cycle_end)
    );

    assign pd_d = d_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StR1;
            ir_q    <= OP_NOP;
            pd_q    <= 8'h00;
        end else if (cycle_end) begin
            state_q <= state_d;
            pd_q    <= pd_d;
            // IR takes the opcode byte PD captures on this same edge.
            if (state_q == StT0) begin
                ir_q <= pd_d;
            end
        end
    end

    // In T1 PD and IR hold the same fresh opcode; later states rely on IR alone.
    assign op = (state_q == StT1) ? pd_q : ir_q;

    always_comb begin
        state_d = state_q;
        ctl_raw = '0;
        unique case (state_q)
            StR1: begin
                ctl_raw.z_adl0  = 1'b1;
                ctl_raw.z_adl1  = 1'b1;
                ctl_raw.adl_abl = 1'b1;
                ctl_raw.adh_abh = 1'b1;
                state_d         = StR2;
            end
            StR2: begin
                ctl_raw.z_adl1  = 1'b1;
                ctl_raw.adl_abl = 1'b1;
                ctl_raw.adh_abh = 1'b1;
                ctl_raw.dl_db   = 1'b1;
                ctl_raw.db_add  = 1'b1;
                ctl_raw.z_add   = 1'b1;
                ctl_raw.sums    = 1'b1;
                state_d         = StR3;
            end
            StR3: begin
                ctl_raw = jump_ctl();
                state_d = StT0;
            end
            StT0: begin
                ctl_raw = pc_fetch_ctl(1'b1);
                state_d = StT1;
            end
            StT1: begin
                state_d = StT0;
                case (op)
                    OP_TAX: begin ctl_raw.ac_sb = 1'b1; ctl_raw.sb_x  = 1'b1; end
                    OP_TAY: begin ctl_raw.ac_sb = 1'b1; ctl_raw.sb_y  = 1'b1; end
                    OP_TXA: begin ctl_raw.x_sb  = 1'b1; ctl_raw.sb_ac = 1'b1; end
                    OP_TYA: begin ctl_raw.y_sb  = 1'b1; ctl_raw.sb_ac = 1'b1; end
                    OP_TXS: begin ctl_raw.x_sb  = 1'b1; ctl_raw.sb_s  = 1'b1; end
                    OP_TSX: begin ctl_raw.s_sb  = 1'b1; ctl_raw.sb_x  = 1'b1; end
                    OP_NOP: ;
                    OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM, OP_JMP_ABS: begin
                        ctl_raw = pc_fetch_ctl(1'b1);
                        state_d = StT2;
                    end
                    default: begin
`ifdef K6502_CTL_ILLEGAL_TRAP_EN
                        state_d = StJam;
`else
                        state_d = StT0;
`endif
                    end
                endcase
            end
            StT2: begin
                state_d = StT0;
                if (op == OP_JMP_ABS) begin
                    ctl_raw        = pc_fetch_ctl(1'b0);
                    ctl_raw.dl_db  = 1'b1;
                    ctl_raw.db_add = 1'b1;
                    ctl_raw.z_add  = 1'b1;
                    ctl_raw.sums   = 1'b1;
                    state_d        = StT3;
                end else begin
                    ctl_raw.dl_db = 1'b1;
                    ctl_raw.sb_db = 1'b1;
                    case (op)
                        OP_LDA_IMM: ctl_raw.sb_ac = 1'b1;
                        OP_LDX_IMM: ctl_raw.sb_x  = 1'b1;
                        OP_LDY_IMM: ctl_raw.sb_y  = 1'b1;
                        default: ;
                    endcase
                end
            end
            StT3: begin
                ctl_raw = jump_ctl();
                state_d = StT0;
            end
            StJam: begin
                state_d = StJam;
            end
            default: begin
                state_d = StR1;
            end
        endcase
    end

    // Outputs stay at reset values until the phase generator starts the first cycle.
    assign running = ph1 | ph2;
    assign ctl     = running ? ctl_raw : '0;
    assign sync    = running && (state_q == StT0);
    assign t_state = running ? state_q : 3'd0;
    assign rw      = 1'b1;

`ifdef K6502_CTL_ILLEGAL_TRAP_EN
    assign jam = (state_q == StJam);
`else
    assign jam = 1'b0;
`endif

endmodule

// File: tb/tb_k6502_control.sv
// Randomized bench for k6502_control against an instruction-level cycle model.
module tb_k6502_control;
    import k6502_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       d_in = 8'h00;
    logic             ph1, ph2, rw, sync, jam;
    logic [2:0]       t_state;
    control_signals_t ctl;

    k6502_control dut (
        .clk     (clk),
        .rst     (rst),
        .d_in    (d_in),
        .ph1     (ph1),
        .ph2     (ph2),
        .ctl     (ctl),
        .rw      (rw),
        .sync    (sync),
        .t_state (t_state),
        .jam     (jam)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       din;
        control_signals_t ctl;
        logic             sync;
        logic [2:0]       t;
        logic             jam;
    } cyc_t;

    cyc_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   jammed   = 0;

    localparam int NLEGAL = 11;
    logic [7:0] legal_ops [NLEGAL] = '{8'hAA, 8'hA8, 8'h8A, 8'h98, 8'h9A, 8'hBA, 8'hEA,
                                       8'hA9, 8'hA2, 8'hA0, 8'h4C};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    endtask

    function automatic control_signals_t fetch_word(input logic inc);
        control_signals_t c = '0;
        c.pcl_adl = 1; c.pch_adh = 1; c.adl_abl = 1; c.adh_abh = 1;
        c.pcl_pcl = 1; c.pch_pch = 1; c.i_pc = inc;
        return c;
    endfunction

    function automatic control_signals_t load_pc_word();
        control_signals_t c = '0;
        c.dl_adh = 1; c.adh_pch = 1; c.add_adl = 1; c.adl_pcl = 1; c.adl_abl = 1; c.adh_abh = 1;
        return c;
    endfunction

    function automatic bit is_legal(input logic [7:0] op);
        for (int i = 0; i < NLEGAL; i++) if (legal_ops[i] == op) return 1;
        return 0;
    endfunction

    task automatic push(input logic [7:0] din, input control_signals_t c, input logic s,
                        input logic [2:0] t, input logic j);
        cyc_t e;
        e.din = din; e.ctl = c; e.sync = s; e.t = t; e.jam = j;
        exp_q.push_back(e);
    endtask

    // Reset vector: FFFC then FFFD, PC loaded in the third cycle.
    task automatic push_reset_seq();
        control_signals_t c;
        c = '0; c.z_adl0 = 1; c.z_adl1 = 1; c.adl_abl = 1; c.adh_abh = 1;
        push(8'($urandom), c, 0, 3'd5, 0);
        c = '0; c.z_adl1 = 1; c.adl_abl = 1; c.adh_abh = 1;
        c.dl_db = 1; c.db_add = 1; c.z_add = 1; c.sums = 1;
        push(8'h00, c, 0, 3'd6, 0);
        push(8'h80, load_pc_word(), 0, 3'd7, 0);
    endtask

    // One instruction's worth of expected cycles, starting with its opcode fetch.
    task automatic push_insn(input logic [7:0] op);
        control_signals_t c;
        push(op, fetch_word(1), 1, 3'd0, 0);
        c = '0;
        case (op)
            8'hAA: begin c.ac_sb = 1; c.sb_x  = 1; push(8'($urandom), c, 0, 3'd1, 0); end
            8'hA8: begin c.ac_sb = 1; c.sb_y  = 1; push(8'($urandom), c, 0, 3'd1, 0); end
            8'h8A: begin c.x_sb  = 1; c.sb_ac = 1; push(8'($urandom), c, 0, 3'd1, 0); end
            8'h98: begin c.y_sb  = 1; c.sb_ac = 1; push(8'($urandom), c, 0, 3'd1, 0); end
            8'h9A: begin c.x_sb  = 1; c.sb_s  = 1; push(8'($urandom), c, 0, 3'd1, 0); end
            8'hBA: begin c.s_sb  = 1; c.sb_x  = 1; push(8'($urandom), c, 0, 3'd1, 0); end
            8'hEA: push(8'($urandom), c, 0, 3'd1, 0);
            8'hA9, 8'hA2, 8'hA0: begin
                push(8'($urandom), fetch_word(1), 0, 3'd1, 0);
                c.dl_db = 1; c.sb_db = 1;
                if (op == 8'hA9) c.sb_ac = 1;
                else if (op == 8'hA2) c.sb_x = 1;
                else c.sb_y = 1;
                push(8'($urandom), c, 0, 3'd2, 0);
            end
            8'h4C: begin
                push(8'h34, fetch_word(1), 0, 3'd1, 0);
                c = fetch_word(0); c.dl_db = 1; c.db_add = 1; c.z_add = 1; c.sums = 1;
                push(8'h12, c, 0, 3'd2, 0);
                push(8'($urandom), load_pc_word(), 0, 3'd3, 0);
            end
            default: begin
                push(8'($urandom), c, 0, 3'd1, 0);
`ifdef K6502_CTL_ILLEGAL_TRAP_EN
                repeat (3) push(8'($urandom), c, 0, 3'd4, 1);
                jammed = 1;
`endif
            end
        endcase
    endtask

    task automatic check_reset_vals();
        check_eq("rst_ph1", 32'(ph1), 32'd0);
        check_eq("rst_ph2", 32'(ph2), 32'd0);
        check_eq("rst_ctl", 32'(ctl), 32'd0);
        check_eq("rst_sync", 32'(sync), 32'd0);
        check_eq("rst_t", 32'(t_state), 32'd0);
        check_eq("rst_jam", 32'(jam), 32'd0);
        check_eq("rst_rw", 32'(rw), 32'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals();
        rst = 1'b0;
    endtask

    task automatic check_phase(input cyc_t e);
        check_eq("ctl", 32'(ctl), 32'(e.ctl));
        check_eq("sync", 32'(sync), 32'(e.sync));
        check_eq("t_state", 32'(t_state), 32'(e.t));
        check_eq("jam", 32'(jam), 32'(e.jam));
        check_eq("rw", 32'(rw), 32'd1);
    endtask

    task automatic run_cycle(input cyc_t e);
        @(posedge clk); #1;
        check_eq("ph1_hi", 32'({ph1, ph2}), 32'b10);
        check_phase(e);
        d_in = e.din;
        @(posedge clk); #1;
        check_eq("ph2_hi", 32'({ph1, ph2}), 32'b01);
        check_phase(e);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) run_cycle(exp_q.pop_front());
    endtask

    task automatic run_insn(input logic [7:0] op);
        push_insn(op);
        drain();
        if (jammed) begin
            apply_reset();
            push_reset_seq();
            drain();
            jammed = 0;
        end
    endtask

    initial begin
        logic [7:0] directed [11] = '{8'hA9, 8'hAA, 8'hA8, 8'h8A, 8'h98, 8'h9A, 8'hBA,
                                     8'h4C, 8'hEA, 8'h02, 8'hA2};
        logic [7:0] op;
        cyc_t       e;

        apply_reset();
        push_reset_seq();
        drain();

        foreach (directed[i]) run_insn(directed[i]);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 8'($urandom); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, NLEGAL - 1)];
            end
            run_insn(op);
        end

        // Reset landing in the middle of JMP T2 ph1 must abandon the instruction.
        push_insn(8'h4C);
        run_cycle(exp_q.pop_front());
        run_cycle(exp_q.pop_front());
        e = exp_q.pop_front();
        @(posedge clk); #1;
        check_phase(e);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals();
        rst = 1'b0;
        exp_q.delete();
        push_reset_seq();
        drain();
        run_insn(8'hBA);
        run_insn(8'hA0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
